fu_issue_fifo: RTL and testbench

//   Per-FU-class issue buffer directly downstream of the reservation station (RS).

---
 rtl/fu_issue_fifo_pkg.sv | 22 ++
 rtl/fu_issue_fifo_push_compact.sv | 31 +++
 rtl/fu_issue_fifo.sv | 87 ++++++++
 tb/tb_fu_issue_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fu_issue_fifo_pkg.sv
// Shared types for the per-FU-class issue buffer: RS packet layout, FU class
// encoding and default sizing.
package fu_issue_fifo_pkg;

  localparam int FU_FIFO_DEPTH = 8;
  localparam int FU_IN_LANES   = 3;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MUL    = 2'd1,
    FU_LDST   = 2'd2,
    FU_BRANCH = 2'd3
  } fu_class_e;

  typedef struct packed {
    logic [7:0]  tag;
    fu_class_e   fu_class;
    logic [5:0]  dest;
    logic [15:0] imm;
  } rs_s_packet_t;

endpackage

// File: rtl/fu_issue_fifo_push_compact.sv
// Prefix-sum of the issue lanes: gives each valid lane its slot offset from tail
// and accepts only lanes whose offset fits into the currently free space.
module fu_issue_fifo_push_compact #(
  parameter int DEPTH    = 8,
  parameter int IN_LANES = 3,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic [IN_LANES-1:0] valid,
  input  logic [CW-1:0]       free,
  output logic [AW-1:0]       offset [IN_LANES],
  output logic [IN_LANES-1:0] accept,
  output logic [CW-1:0]       accepted
);

  logic [CW-1:0] run;

  always_comb begin
    run      = '0;
    accepted = '0;
    accept   = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      offset[i] = AW'(run);
      // offsets grow with lane index, so the dropped lanes are always the highest ones
      accept[i] = valid[i] && (run < free);
      accepted  = accepted + CW'(accept[i]);
      run       = run + CW'(valid[i]);
    end
  end

endmodule

// File: rtl/fu_issue_fifo.sv
// Issue buffer between the reservation station and one FU class: multi-lane
// compacted push, single first-word-fall-through pop, stall derived from count.
module fu_issue_fifo
  import fu_issue_fifo_pkg::*;
#(
  parameter int DEPTH    = FU_FIFO_DEPTH,
  parameter int IN_LANES = FU_IN_LANES,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                squash_flush,
  input  logic [IN_LANES-1:0] push_valid,
  input  rs_s_packet_t        push_pkts [IN_LANES],
  input  logic                fu_ready,
  output logic                fu_valid,
  output rs_s_packet_t        fu_pkt,
  output logic                fifo_stall,
  output logic [CW-1:0]       count,
  output logic                overflow_err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LANES_C = CW'(IN_LANES);

  rs_s_packet_t        mem [DEPTH];
  logic [AW-1:0]       head;
  logic [AW-1:0]       tail;
  logic [CW-1:0]       free;
  logic [AW-1:0]       offset [IN_LANES];
  logic [AW-1:0]       waddr  [IN_LANES];
  logic [IN_LANES-1:0] accept;
  logic [CW-1:0]       accepted;
  logic                pop;

  // free space comes from registered count only, so a same-cycle pop never frees a slot
  assign free       = DEPTH_C - count;
  assign fifo_stall = free < LANES_C;
  assign fu_valid   = count != '0;
  assign fu_pkt     = fu_valid ? mem[head] : '0;
  assign pop        = fu_valid && fu_ready;

  fu_issue_fifo_push_compact #(
    .DEPTH    (DEPTH),
    .IN_LANES (IN_LANES)
  ) u_push_compact (
    .valid    (push_valid),
    .free     (free),
    .offset   (offset),
    .accept   (accept),
    .accepted (accepted)
  );

  always_comb begin
    for (int i = 0; i < IN_LANES; i++) begin
      waddr[i] = tail + offset[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !squash_flush) begin
      for (int i = 0; i < IN_LANES; i++) begin
        if (accept[i]) mem[waddr[i]] <= push_pkts[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (squash_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + accepted[AW-1:0];
      count <= count + accepted - CW'(pop);
      if ((push_valid & ~accept) != '0) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fu_issue_fifo.sv
// Self-checking bench for fu_issue_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the buffer.
module tb_fu_issue_fifo;
  import fu_issue_fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int LANES = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         squash_flush;
  logic [2:0]   push_valid;
  rs_s_packet_t push_pkts [LANES];
  logic         fu_ready;
  logic         fu_valid;
  rs_s_packet_t fu_pkt;
  logic         fifo_stall;
  logic [3:0]   count;
  logic         overflow_err;

  rs_s_packet_t q[$];
  logic         m_ovf;
  rs_s_packet_t stim [LANES];
  logic [7:0]   next_tag;
  int checks;
  int errors;

  always #5 clk = ~clk;

  fu_issue_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .squash_flush (squash_flush),
    .push_valid   (push_valid),
    .push_pkts    (push_pkts),
    .fu_ready     (fu_ready),
    .fu_valid     (fu_valid),
    .fu_pkt       (fu_pkt),
    .fifo_stall   (fifo_stall),
    .count        (count),
    .overflow_err (overflow_err)
  );

  function automatic rs_s_packet_t exp_pkt();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  task automatic new_pkts();
    for (int i = 0; i < LANES; i++) begin
      stim[i] = rs_s_packet_t'($urandom);
      stim[i].tag = next_tag;
      next_tag = next_tag + 8'd1;
    end
  endtask

  // drive one cycle, then advance the model by the buffer's rules
  task automatic cycle(input logic [2:0] pv, input logic rdy, input logic fl, input logic rs);
    rs_s_packet_t add[$];
    int free;
    bit do_pop;
    push_valid   = pv;
    fu_ready     = rdy;
    squash_flush = fl;
    rst          = rs;
    for (int i = 0; i < LANES; i++) push_pkts[i] = stim[i];
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      q.delete();
    end else begin
      free   = DEPTH - q.size();
      do_pop = (q.size() > 0) && rdy;
      for (int i = 0; i < LANES; i++) begin
        if (pv[i]) begin
          if (add.size() < free) add.push_back(stim[i]);
          else m_ovf = 1'b1;
        end
      end
      if (do_pop) void'(q.pop_front());
      foreach (add[i]) q.push_back(add[i]);
    end
    #1;
  endtask

  task automatic do_reset();
    new_pkts();
    cycle(3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    cycle(3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL reset_fu_valid got=%0b exp=0", fu_valid); end
    checks++; if (fu_pkt !== '0) begin errors++; $display("FAIL reset_fu_pkt got=%h exp=0", fu_pkt); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (fifo_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", fifo_stall); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", overflow_err); end
  endtask

  task automatic test_compact_push();
    rs_s_packet_t a, c;
    do_reset();
    new_pkts();
    a = stim[0];
    c = stim[2];
    cycle(3'b101, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL compact_count got=%0d exp=2", count); end
    checks++; if (fu_pkt !== a) begin errors++; $display("FAIL compact_head_a got=%h exp=%h", fu_pkt, a); end
    cycle(3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (fu_pkt !== c) begin errors++; $display("FAIL compact_head_c got=%h exp=%h", fu_pkt, c); end
    cycle(3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL compact_drained got=%0d exp=0", count); end
    checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL compact_valid got=%0b exp=0", fu_valid); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] dropped;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      new_pkts();
      cycle(3'b111, 1'b0, 1'b0, 1'b0);
    end
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL fill_count6 got=%0d exp=6", count); end
    checks++; if (fifo_stall !== 1'b1) begin errors++; $display("FAIL fill_stall got=%0b exp=1", fifo_stall); end
    new_pkts();
    dropped = stim[2].tag;
    cycle(3'b111, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count8 got=%0d exp=8", count); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL fill_ovf got=%0b exp=1", overflow_err); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (fu_pkt !== exp_pkt()) begin errors++; $display("FAIL drain_pkt[%0d] got=%h exp=%h", k, fu_pkt, exp_pkt()); end
      checks++; if (fu_pkt.tag === dropped) begin errors++; $display("FAIL drain_dropped_present[%0d] got tag=%h must not be %h", k, fu_pkt.tag, dropped); end
      new_pkts();
      cycle(3'b000, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    logic [2:0] pv;
    do_reset();
    new_pkts(); cycle(3'b111, 1'b0, 1'b0, 1'b0);
    new_pkts(); cycle(3'b011, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_empty got=%0d exp=0", count); end
    for (int k = 0; k < 10; k++) begin
      pv = (k < 2) ? 3'b111 : 3'b000;
      new_pkts();
      cycle(pv, 1'b1, 1'b0, 1'b0);
      checks++; if (fu_pkt !== exp_pkt()) begin errors++; $display("FAIL wrap_pkt[%0d] got=%h exp=%h", k, fu_pkt, exp_pkt()); end
      checks++; if (count !== 4'(q.size()) || count > 4'd8) begin errors++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", k, count, q.size()); end
    end
  endtask

  task automatic test_push_pop_boundary();
    do_reset();
    new_pkts(); cycle(3'b111, 1'b0, 1'b0, 1'b0);
    new_pkts(); cycle(3'b111, 1'b0, 1'b0, 1'b0);
    new_pkts(); cycle(3'b001, 1'b0, 1'b0, 1'b0);
    new_pkts(); cycle(3'b001, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL bnd_count7 got=%0d exp=7", count); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL bnd_ovf7 got=%0b exp=0", overflow_err); end
    new_pkts(); cycle(3'b001, 1'b0, 1'b0, 1'b0);
    new_pkts(); cycle(3'b001, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL bnd_full_pop got=%0d exp=7", count); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL bnd_ovf8 got=%0b exp=1", overflow_err); end
    checks++; if (fu_pkt !== exp_pkt()) begin errors++; $display("FAIL bnd_head got=%h exp=%h", fu_pkt, exp_pkt()); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin new_pkts(); cycle(3'b111, 1'b0, 1'b0, 1'b0); end
    cycle(3'b000, 1'b0, 1'b1, 1'b0);
    new_pkts(); cycle(3'b111, 1'b0, 1'b0, 1'b0);
    new_pkts(); cycle(3'b001, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL flush_pre got=%0d exp=4", count); end
    new_pkts(); cycle(3'b011, 1'b1, 1'b1, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", fu_valid); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL flush_ovf_kept got=%0b exp=1", overflow_err); end
    new_pkts(); cycle(3'b111, 1'b0, 1'b0, 1'b0);
    new_pkts(); cycle(3'b001, 1'b0, 1'b0, 1'b0);
    new_pkts(); cycle(3'b011, 1'b1, 1'b1, 1'b1);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", fu_valid); end
    checks++; if (fu_pkt !== '0) begin errors++; $display("FAIL rst_pkt got=%h exp=0", fu_pkt); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%0b exp=0", overflow_err); end
  endtask

  task automatic test_random();
    logic [2:0] pv;
    logic rdy, fl;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      pv  = 3'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 31) == 0);
      new_pkts();
      cycle(pv, rdy, fl, 1'b0);
      checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", k, count, q.size()); end
      checks++; if (fu_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", k, fu_valid, q.size() > 0); end
      checks++; if (fu_pkt !== exp_pkt()) begin errors++; $display("FAIL rnd_pkt[%0d] got=%h exp=%h", k, fu_pkt, exp_pkt()); end
      checks++; if (fifo_stall !== ((DEPTH - q.size()) < LANES)) begin errors++; $display("FAIL rnd_stall[%0d] got=%0b exp=%0b", k, fifo_stall, (DEPTH - q.size()) < LANES); end
      checks++; if (overflow_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got=%0b exp=%0b", k, overflow_err, m_ovf); end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    next_tag     = 8'd1;
    m_ovf        = 1'b0;
    rst          = 1'b1;
    squash_flush = 1'b0;
    push_valid   = '0;
    fu_ready     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      stim[i]      = '0;
      push_pkts[i] = '0;
    end
    test_reset();
    test_compact_push();
    test_fill_overflow();
    test_wrap();
    test_push_pop_boundary();
    test_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
